// File: rtl/writeback_pipe.sv
// Writeback staging pipe: results land at their latency stage, shift to the last stage, and drive one RF write port.
// Optional operand forwarding from in-flight stages is compiled in with `define WB_FWD_EN.
module writeback_pipe #(
    parameter int unsigned QUADWORD   = 128,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned STAGES     = 7,
    parameter int unsigned LAT_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  result_valid,
    input  logic [LAT_W-1:0]      result_lat,
    input  logic [ADDR_WIDTH-1:0] result_addr,
    input  logic [QUADWORD-1:0]   result_data,
    output logic                  regWr_en,
    output logic [ADDR_WIDTH-1:0] addr_rt_wt,
    output logic [QUADWORD-1:0]   rt_wt,
    input  logic [ADDR_WIDTH-1:0] fwd_addr,
    output logic                  fwd_hit,
    output logic [QUADWORD-1:0]   fwd_data,
    output logic                  busy,
    output logic                  collision,
    output logic                  lat_err
);

    logic [STAGES:1]       v_q, v_d;
    logic [ADDR_WIDTH-1:0] addr_q [1:STAGES];
    logic [ADDR_WIDTH-1:0] addr_d [1:STAGES];
    logic [QUADWORD-1:0]   data_q [1:STAGES];
    logic [QUADWORD-1:0]   data_d [1:STAGES];
    logic [STAGES:1]       ins;
    logic                  collision_q, collision_d;
    logic                  lat_err_q, lat_err_d;

    always_comb begin
        for (int unsigned s = 1; s <= STAGES; s++) begin
            ins[s] = result_valid && (result_lat == LAT_W'(s));
        end
    end

    // addr/data only load when a valid entry arrives, so the write stage holds its last written values
    always_comb begin
        v_d[1]      = ins[1];
        addr_d[1]   = ins[1] ? result_addr : addr_q[1];
        data_d[1]   = ins[1] ? result_data : data_q[1];
        collision_d = 1'b0;
        for (int unsigned s = 2; s <= STAGES; s++) begin
            v_d[s]    = 1'b0;
            addr_d[s] = addr_q[s];
            data_d[s] = data_q[s];
            if (ins[s]) begin
                v_d[s]    = 1'b1;
                addr_d[s] = result_addr;
                data_d[s] = result_data;
                if (v_q[s-1]) collision_d = 1'b1;
            end else if (v_q[s-1]) begin
                v_d[s]    = 1'b1;
                addr_d[s] = addr_q[s-1];
                data_d[s] = data_q[s-1];
            end
        end
        lat_err_d = result_valid && (ins == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q         <= '0;
            collision_q <= 1'b0;
            lat_err_q   <= 1'b0;
            for (int unsigned s = 1; s <= STAGES; s++) begin
                addr_q[s] <= '0;
                data_q[s] <= '0;
            end
        end else begin
            v_q         <= v_d;
            collision_q <= collision_d;
            lat_err_q   <= lat_err_d;
            for (int unsigned s = 1; s <= STAGES; s++) begin
                addr_q[s] <= addr_d[s];
                data_q[s] <= data_d[s];
            end
        end
    end

    assign regWr_en   = v_q[STAGES];
    assign addr_rt_wt = addr_q[STAGES];
    assign rt_wt      = data_q[STAGES];
    assign busy       = |v_q;
    assign collision  = collision_q;
    assign lat_err    = lat_err_q;

`ifdef WB_FWD_EN
    // scan oldest to youngest so the lowest matching stage overrides
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (v_q[STAGES-i] && (addr_q[STAGES-i] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[STAGES-i];
            end
        end
    end
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit         = 1'b0;
    assign fwd_data        = '0;
`endif

endmodule
